// File: rtl/seq_stage_controller.sv
// Multi-cycle SEQ Y86-64 stage sequencer: one strobe per stage, data-memory handshake and status code.
// Optional performance counters are enabled by defining SEQ_PERF_CNT_EN.
module seq_stage_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_ack,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             dmem_req,
    output logic             wb_en,
    output logic             pc_en,
    output logic [1:0]       stat,
    output logic             busy,
`ifdef SEQ_PERF_CNT_EN
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic [2:0]       state
);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
        $error("seq_stage_controller: MEM_TIMEOUT and CNT_W must be >= 1");
    end

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PCUPD  = 3'd6,
        S_STOP   = 3'd7
    } state_t;

    localparam logic [1:0] ST_AOK = 2'b00;
    localparam logic [1:0] ST_HLT = 2'b01;
    localparam logic [1:0] ST_ADR = 2'b10;
    localparam logic [1:0] ST_INS = 2'b11;

    state_t           state_q, state_n;
    logic [1:0]       stat_q, stat_n;
    logic [WCW-1:0]   wait_q, wait_n;
    logic [3:0]       icode_q;
    logic             is_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stat_q  <= ST_AOK;
            wait_q  <= '0;
            icode_q <= '0;
        end else begin
            state_q <= state_n;
            stat_q  <= stat_n;
            wait_q  <= wait_n;
            if (state_q == S_FETCH)
                icode_q <= icode;
        end
    end

    // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
    assign is_mem = (icode_q == 4'd4) || (icode_q == 4'd5) || (icode_q == 4'd8) ||
                    (icode_q == 4'd9) || (icode_q == 4'd10) || (icode_q == 4'd11);

    always_comb begin
        state_n = state_q;
        stat_n  = stat_q;
        wait_n  = wait_q;
        case (state_q)
            S_IDLE:   if (start) state_n = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    state_n = S_STOP;
                    stat_n  = ST_ADR;
                end else if (!instr_valid) begin
                    state_n = S_STOP;
                    stat_n  = ST_INS;
                end else if (icode == 4'd0) begin
                    state_n = S_STOP;
                    stat_n  = ST_HLT;
                end else begin
                    state_n = S_DECODE;
                end
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC:   state_n = S_MEM;
            S_MEM: begin
                if (!is_mem) begin
                    state_n = S_WB;
                end else if (dmem_error) begin
                    state_n = S_STOP;
                    stat_n  = ST_ADR;
                    wait_n  = '0;
                end else if (dmem_ack) begin
                    state_n = S_WB;
                    wait_n  = '0;
                end else if (wait_q == WCW'(MEM_TIMEOUT - 1)) begin
                    state_n = S_STOP;
                    stat_n  = ST_ADR;
                    wait_n  = '0;
                end else begin
                    wait_n  = wait_q + 1'b1;
                end
            end
            S_WB:     state_n = S_PCUPD;
            S_PCUPD:  state_n = S_FETCH;
            S_STOP: begin
                // only HLT is resumable; ADR/INS stay until reset
                if (start && stat_q == ST_HLT) begin
                    state_n = S_FETCH;
                    stat_n  = ST_AOK;
                end
            end
            default:  state_n = S_IDLE;
        endcase
    end

    assign fetch_en   = (state_q == S_FETCH);
    assign decode_en  = (state_q == S_DECODE);
    assign execute_en = (state_q == S_EXEC);
    assign memory_en  = (state_q == S_MEM);
    assign dmem_req   = (state_q == S_MEM) && is_mem;
    assign wb_en      = (state_q == S_WB);
    assign pc_en      = (state_q == S_PCUPD);
    assign busy       = (state_q != S_IDLE) && (state_q != S_STOP);
    assign stat       = stat_q;
    assign state      = state_q;

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy)
                cyc_cnt <= cyc_cnt + 1'b1;
            if (pc_en)
                instr_cnt <= instr_cnt + 1'b1;
            if (dmem_req && wait_q != '0)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
